// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic valid/ready pipeline-stage register for the five-stage CPU. Carries
// NCH bundled lanes of DATA_W bits each. A main entry drives the outputs and a
// skid entry absorbs one extra word, so in_ready can come straight from a flop
// and never depends combinationally on out_ready. When the stage holds nothing,
// the instruction lane shows a NOP so downstream decode sees a harmless
// instruction.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, the stall_cycles and bubble_cycles counters and their ports
//   are built. Handshake behaviour is the same in both builds.
//
// Parameters:
//   DATA_W  width of one lane
//   NCH     number of lanes
//   IR_CH   index of the lane carrying the instruction word
//   NOP_IR  instruction driven on the IR lane when empty (low DATA_W bits used)
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   flush          synchronous kill of all held entries
//   in_valid       upstream has data
//   in_ready       stage can accept (registered)
//   in_data        lane k at bits [k*DATA_W +: DATA_W]
//   out_valid      main entry valid
//   out_ready      downstream accepts
//   out_data       main entry; IR lane forced to NOP_IR when out_valid=0
//   stall_cycles   cycles with out_valid & !out_ready (PIPE_STAGE_PERF_EN only)
//   bubble_cycles  cycles with !out_valid (PIPE_STAGE_PERF_EN only)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NCH    = 5,
    parameter int unsigned IR_CH  = 0,
    parameter logic [31:0] NOP_IR = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bubble_cycles
`endif
);

    localparam int unsigned  W        = NCH * DATA_W;
    localparam int unsigned  IR_LSB   = IR_CH * DATA_W;
    localparam logic [DATA_W-1:0] NOP_LANE = DATA_W'(NOP_IR);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Saturating increment used by the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   main_q,  main_d;
    logic [W-1:0]   skid_q,  skid_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic           accept_s;
    logic           drain_s;

    // Handshake qualifiers; both use registered flags only.
    assign accept_s = in_valid & in_ready_q;
    assign drain_s  = out_valid_q & out_ready;

    // Next-state and data-movement logic for the main/skid pair.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end else if (accept_s) begin
                    skid_d  = in_data;
                    state_d = ST_FULL;
                end else if (drain_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can move state.
                if (drain_s) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush wins: any same-cycle accept is dropped, stored words keep
        // their old values so the non-IR lanes still show the last main word.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end else begin
            state_d = state_d;
        end

        // Flags are precomputed from the next state so they leave a flop.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, storage and handshake flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= {W{1'b0}};
            skid_q      <= {W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output lanes come from the main register; IR lane shows NOP when empty.
    always_comb begin
        out_data = main_q;
        if (!out_valid_q) begin
            out_data[IR_LSB +: DATA_W] = NOP_LANE;
        end else begin
            out_data[IR_LSB +: DATA_W] = main_q[IR_LSB +: DATA_W];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] bubble_cycles_q;

    // Saturating stall and bubble counters; cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q  <= 32'd0;
            bubble_cycles_q <= 32'd0;
        end else begin
            if (out_valid_q && !out_ready) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end else begin
                stall_cycles_q <= stall_cycles_q;
            end
            if (!out_valid_q) begin
                bubble_cycles_q <= sat_inc(bubble_cycles_q);
            end else begin
                bubble_cycles_q <= bubble_cycles_q;
            end
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_cycles = bubble_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. A behavioural model holds the stage
// contents as a queue of at most two words: the head is what the stage shows,
// a drain pops, an accept pushes, flush clears. Expected outputs come from that
// queue. Build with PIPE_STAGE_PERF_EN to also check the counters.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW  = 32;
    localparam int NC  = 5;
    localparam int IRC = 0;
    localparam int W   = DW * NC;
    localparam logic [31:0] NOP = 32'h00000013;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cycles;
    logic [31:0]  bubble_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [W-1:0] mq[$];
    logic [W-1:0] last_main = '0;
    logic [31:0]  m_stall  = 32'd0;
    logic [31:0]  m_bubble = 32'd0;

    pipe_stage_reg #(
        .DATA_W(DW), .NCH(NC), .IR_CH(IRC), .NOP_IR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_word(input logic [31:0] ir);
        logic [W-1:0] v;
        for (int k = 0; k < NC; k++) v[k*DW +: DW] = $urandom;
        v[IRC*DW +: DW] = ir;
        return v;
    endfunction

    function automatic logic [W-1:0] exp_data();
        logic [W-1:0] v;
        if (mq.size() > 0) begin
            v = mq[0];
        end else begin
            v = last_main;
            v[IRC*DW +: DW] = NOP;
        end
        return v;
    endfunction

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        mq.delete();
        last_main = '0;
        m_stall   = 32'd0;
        m_bubble  = 32'd0;
    endtask

    // Apply one cycle of inputs (called at a negedge), advance the model at
    // the rising edge, and return at the following negedge.
    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        bit acc, drn;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        acc = iv && (mq.size() < 2);
        drn = (mq.size() > 0) && ordy;
        if (mq.size() == 0) m_bubble = sat1(m_bubble);
        else if (!ordy)     m_stall  = sat1(m_stall);
        if (fl) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        if (mq.size() > 0) last_main = mq[0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [W-1:0] rv;
        rv = '0;
        rv[IRC*DW +: DW] = NOP;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_checks++;
        if (out_data !== rv) begin
            n_fail++; $display("FAIL reset_out_data got=%h exp=%h", out_data, rv);
        end
`ifdef PIPE_STAGE_PERF_EN
        n_checks++;
        if (stall_cycles !== 32'd0 || bubble_cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters got=%h/%h exp=0/0", stall_cycles, bubble_cycles);
        end
`endif
    endtask

    task automatic test_streaming();
        logic [W-1:0] w;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                w = rand_word(32'h100 + 32'(i));
                cycle(1'b1, w, 1'b1, 1'b0);
            end else begin
                cycle(1'b0, '0, 1'b1, 1'b0);
            end
            n_checks++;
            if (i < 3 && (out_valid !== 1'b1 || out_data[IRC*DW +: DW] !== 32'h100 + 32'(i)
                          || out_data !== exp_data())) begin
                n_fail++; $display("FAIL stream_out[%0d] got v=%b d=%h exp ir=%h", i, out_valid, out_data, 32'h100 + 32'(i));
            end
            if (i == 3 && (out_valid !== 1'b0 || out_data !== exp_data())) begin
                n_fail++; $display("FAIL stream_tail got v=%b d=%h exp v=0 d=%h", out_valid, out_data, exp_data());
            end
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready);
            end
        end
    endtask

    task automatic test_skid();
        logic [W-1:0] wa, wb;
        wa = rand_word(32'hA);
        wb = rand_word(32'hB);
        cycle(1'b1, wa, 1'b0, 1'b0);
        cycle(1'b1, wb, 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== wa) begin
            n_fail++; $display("FAIL skid_full got r=%b v=%b d=%h exp r=0 v=1 d=%h", in_ready, out_valid, out_data, wa);
        end
        // A stalled full stage holds.
        cycle(1'b1, rand_word(32'hDEAD), 1'b0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== wa) begin
            n_fail++; $display("FAIL skid_hold got r=%b d=%h exp r=0 d=%h", in_ready, out_data, wa);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== wb) begin
            n_fail++; $display("FAIL skid_drain1 got r=%b v=%b d=%h exp r=1 v=1 d=%h", in_ready, out_valid, out_data, wb);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== exp_data()) begin
            n_fail++; $display("FAIL skid_drain2 got v=%b d=%h exp v=0 d=%h", out_valid, out_data, exp_data());
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] wc;
        wc = rand_word(32'hC);
        cycle(1'b1, rand_word(32'h1A), 1'b0, 1'b0);
        cycle(1'b1, rand_word(32'h1B), 1'b0, 1'b0);
        cycle(1'b1, wc, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data[IRC*DW +: DW] !== NOP
            || out_data !== exp_data()) begin
            n_fail++; $display("FAIL flush_empty got v=%b r=%b d=%h exp v=0 r=1 d=%h", out_valid, in_ready, out_data, exp_data());
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (out_valid !== 1'b0 || out_data[IRC*DW +: DW] === 32'hC) begin
                n_fail++; $display("FAIL flush_no_ghost[%0d] got v=%b ir=%h exp v=0", i, out_valid, out_data[IRC*DW +: DW]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        bit iv, ordy, fl;
        for (int i = 0; i < 400; i++) begin
            w    = rand_word($urandom);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            cycle(iv, w, ordy, fl);
            n_checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)
                || out_data !== exp_data()) begin
                n_fail++; $display("FAIL random[%0d] got v=%b r=%b d=%h exp v=%b r=%b d=%h",
                                   i, out_valid, in_ready, out_data, mq.size() > 0, mq.size() < 2, exp_data());
            end
`ifdef PIPE_STAGE_PERF_EN
            n_checks++;
            if (stall_cycles !== m_stall || bubble_cycles !== m_bubble) begin
                n_fail++; $display("FAIL random_cnt[%0d] got=%h/%h exp=%h/%h", i, stall_cycles, bubble_cycles, m_stall, m_bubble);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] rv;
        rv = '0;
        rv[IRC*DW +: DW] = NOP;
        cycle(1'b1, rand_word(32'h55), 1'b0, 1'b0);
        cycle(1'b1, rand_word(32'h56), 1'b0, 1'b0);
        in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== rv) begin
            n_fail++; $display("FAIL reset_mid got v=%b r=%b d=%h exp v=0 r=1 d=%h", out_valid, in_ready, out_data, rv);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, rand_word(32'h77), 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data()) begin
            n_fail++; $display("FAIL reset_recover got v=%b d=%h exp v=1 d=%h", out_valid, out_data, exp_data());
        end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        logic [31:0] s0;
        cycle(1'b0, '0, 1'b1, 1'b1);
        s0 = m_stall;
        cycle(1'b1, rand_word(32'h9), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (stall_cycles !== s0 + 32'd3 || bubble_cycles !== m_bubble) begin
            n_fail++; $display("FAIL perf_stall3 got=%h/%h exp=%h/%h", stall_cycles, bubble_cycles, s0 + 32'd3, m_bubble);
        end
        force dut.stall_cycles_q = 32'hFFFFFFFE;
        #1 release dut.stall_cycles_q;
        m_stall = 32'hFFFFFFFE;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (stall_cycles !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL perf_saturate got=%h exp=ffffffff", stall_cycles);
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (stall_cycles !== 32'hFFFFFFFF || bubble_cycles !== m_bubble) begin
            n_fail++; $display("FAIL perf_flush_keep got=%h/%h exp=ffffffff/%h", stall_cycles, bubble_cycles, m_bubble);
        end
    endtask
`endif

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
